bitrev_addr_gen: RTL and testbench

Parametrised bit-reversed address generator for the FFT reorder stage. It replaces the fixed-width reverser with a runtime-selectable transform length and a ready/valid output handshake with backpressure. An optional swap-pair mode emits only the indices needed for in-place reordering. It sits between the FFT control sequencer, which issues `start_gen`, and the sample-memory port that consumes `addr`/`addr_cnt`.

---
 rtl/bitrev_addr_gen.sv | 151 +++++++++++++++
 tb/tb_bitrev_addr_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_addr_gen.sv
// bitrev_addr_gen: bit-reversed address generator for the FFT reorder stage.
// Emits natural-order indices (addr_cnt) paired with their bit reversal over
// a runtime-selected length of 2^n points (addr), with a ready/valid handshake.
// Optional feature macro: BITREV_SWAP_EN adds the swap_only input, which limits
// the presented indices to those where cnt < rev_n(cnt). Each such index forms
// one swap pair for in-place reordering.
module bitrev_addr_gen #(
    parameter int ADDR_BITS = 3,
    parameter int LEN_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_gen,
    input  logic [LEN_BITS-1:0]  log2_len,
`ifdef BITREV_SWAP_EN
    input  logic                 swap_only,
`endif
    input  logic                 addr_ready,
    output logic                 addr_valid,
    output logic [ADDR_BITS-1:0] addr,
    output logic [ADDR_BITS-1:0] addr_cnt,
    output logic                 done_gen,
    output logic                 busy
);

    localparam int CNT_W = ADDR_BITS + 1;
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(ADDR_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [LEN_BITS-1:0]  n_reg;
    logic                 addr_valid_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic [ADDR_BITS-1:0] addr_cnt_reg;
    logic                 done_gen_reg;
    logic                 busy_reg;

    logic [LEN_BITS-1:0]  n_start;
    logic [ADDR_BITS-1:0] idx_next;
    logic [ADDR_BITS-1:0] rev_full;
    logic [ADDR_BITS-1:0] rev_next;
    logic [CNT_W-1:0]     cnt_last;
    logic                 present_next;
    logic                 present_start;
    logic                 advance;

    // Requested lengths beyond the address width are clamped to full width.
    assign n_start = (log2_len > MAX_LEN) ? MAX_LEN : log2_len;

    // Index that will be presented after the current one.
    assign idx_next = cnt_reg[ADDR_BITS-1:0] + ADDR_BITS'(1);

    // Full-width mirror of the next index; shifting right by (ADDR_BITS - n)
    // turns it into the reversal of only the low n bits with zeros above n.
    generate
        for (genvar gi = 0; gi < ADDR_BITS; gi++) begin : g_rev
            assign rev_full[gi] = idx_next[ADDR_BITS-1-gi];
        end
    endgenerate

    assign rev_next = rev_full >> (MAX_LEN - n_reg);

    // Final count for the active length; cnt is one bit wider so 2^n fits.
    assign cnt_last = (CNT_W'(1) << n_reg) - CNT_W'(1);

    // A presented index moves on only on a transfer; a skipped one always does.
    assign advance = addr_valid_reg ? addr_ready : 1'b1;

`ifdef BITREV_SWAP_EN
    logic swap_reg;

    // Index 0 reverses to itself, so in swap mode it is never presented.
    assign present_start = !swap_only;
    assign present_next  = !swap_reg || (idx_next < rev_next);
`else
    assign present_start = 1'b1;
    assign present_next  = 1'b1;
`endif

    // Sequencer: IDLE -> RUN -> DONE -> IDLE, with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            n_reg          <= '0;
            addr_valid_reg <= 1'b0;
            addr_reg       <= '0;
            addr_cnt_reg   <= '0;
            done_gen_reg   <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef BITREV_SWAP_EN
            swap_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_gen_reg <= 1'b0;
                    if (start_gen && (log2_len != '0)) begin
                        n_reg          <= n_start;
                        cnt_reg        <= '0;
                        addr_cnt_reg   <= '0;
                        addr_reg       <= '0;
                        addr_valid_reg <= present_start;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_RUN;
`ifdef BITREV_SWAP_EN
                        swap_reg       <= swap_only;
`endif
                    end
                end
                ST_RUN: begin
                    if (advance) begin
                        if (cnt_reg == cnt_last) begin
                            addr_valid_reg <= 1'b0;
                            addr_reg       <= '0;
                            addr_cnt_reg   <= '0;
                            done_gen_reg   <= 1'b1;
                            state_reg      <= ST_DONE;
                        end else begin
                            cnt_reg        <= cnt_reg + CNT_W'(1);
                            addr_cnt_reg   <= idx_next;
                            addr_reg       <= rev_next;
                            addr_valid_reg <= present_next;
                        end
                    end
                end
                ST_DONE: begin
                    done_gen_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr_valid = addr_valid_reg;
    assign addr       = addr_reg;
    assign addr_cnt   = addr_cnt_reg;
    assign done_gen   = done_gen_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_bitrev_addr_gen.sv
// tb_bitrev_addr_gen: self-checking bench for bitrev_addr_gen.
// A default-width instance covers sequencing, backpressure, reset and swap mode.
// A 4-bit instance covers length clamping. Expected values come from an
// index-by-index model that reverses bits arithmetically.
module tb_bitrev_addr_gen;

    localparam int AB  = 3;
    localparam int LB  = 2;
    localparam int AB4 = 4;
    localparam int LB4 = 3;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Default-width instance.
    logic          rst_n = 1'b0;
    logic          start_gen = 1'b0;
    logic [LB-1:0] log2_len = '0;
    logic          addr_ready = 1'b0;
    logic          addr_valid;
    logic [AB-1:0] addr;
    logic [AB-1:0] addr_cnt;
    logic          done_gen;
    logic          busy;
`ifdef BITREV_SWAP_EN
    logic          swap_only = 1'b0;
    logic          swap_b = 1'b0;
`endif

    // Wider instance, used for the clamping checks.
    logic           rst_b_n = 1'b0;
    logic           start_b = 1'b0;
    logic [LB4-1:0] len_b = '0;
    logic           ready_b = 1'b0;
    logic           valid_b;
    logic [AB4-1:0] addr_b;
    logic [AB4-1:0] cnt_b;
    logic           done_b;
    logic           busy_b;

    always #5 clk = ~clk;

    bitrev_addr_gen #(.ADDR_BITS(AB), .LEN_BITS(LB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_gen  (start_gen),
        .log2_len   (log2_len),
`ifdef BITREV_SWAP_EN
        .swap_only  (swap_only),
`endif
        .addr_ready (addr_ready),
        .addr_valid (addr_valid),
        .addr       (addr),
        .addr_cnt   (addr_cnt),
        .done_gen   (done_gen),
        .busy       (busy)
    );

    bitrev_addr_gen #(.ADDR_BITS(AB4), .LEN_BITS(LB4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_b_n),
        .start_gen  (start_b),
        .log2_len   (len_b),
`ifdef BITREV_SWAP_EN
        .swap_only  (swap_b),
`endif
        .addr_ready (ready_b),
        .addr_valid (valid_b),
        .addr       (addr_b),
        .addr_cnt   (cnt_b),
        .done_gen   (done_b),
        .busy       (busy_b)
    );

    // Reverse the low n bits of v by peeling bits off the bottom.
    function automatic int rev_ref(input int v, input int n);
        int r = 0;
        int x = v;
        for (int i = 0; i < n; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // One full sequence on the default instance. Entered and left on a negedge
    // with the DUT idle. The model walks indices 0..2^n-1; a presented index
    // waits for ready, and a skipped one costs exactly one cycle.
    task automatic run_seq(input int len, input bit swp, input int ready_pct,
                           input int stall_idx, input string tag);
        int n;
        int total;
        int idx;
        int r;
        int xfers;
        int exp_xfers;
        int stall_left;
        int cyc;
        bit pres;
        n = (len > AB) ? AB : len;
        total = 1 << n;
        idx = 0;
        xfers = 0;
        exp_xfers = 0;
        stall_left = 3;
        cyc = 0;
        for (int i = 0; i < total; i++)
            if (!swp || i < rev_ref(i, n)) exp_xfers++;
        log2_len = LB'(len);
        start_gen = 1'b1;
`ifdef BITREV_SWAP_EN
        swap_only = swp;
`endif
        @(negedge clk);
        start_gen = 1'b0;
        while (idx < total && cyc < 400) begin
            r = rev_ref(idx, n);
            pres = !swp || (idx < r);
            checks++;
            if (addr_valid !== pres || busy !== 1'b1 || done_gen !== 1'b0) begin
                failures++;
                $display("FAIL %s_ctrl idx=%0d: valid=%b busy=%b done=%b, expected valid=%b busy=1 done=0",
                         tag, idx, addr_valid, busy, done_gen, pres);
            end
            if (pres) begin
                checks++;
                if (addr_cnt !== AB'(idx) || addr !== AB'(r)) begin
                    failures++;
                    $display("FAIL %s_addr: addr_cnt=%0d addr=%0d, expected addr_cnt=%0d addr=%0d",
                             tag, addr_cnt, addr, idx, r);
                end
            end
            if (idx == stall_idx && stall_left > 0) begin
                addr_ready = 1'b0;
                stall_left--;
            end else begin
                addr_ready = ($urandom_range(99) < ready_pct);
            end
            if (pres && addr_ready) xfers++;
            if (!pres || addr_ready) idx++;
            // Stray starts with random lengths while running must be ignored.
            start_gen = ($urandom_range(3) == 0);
            log2_len = LB'($urandom_range(3));
            cyc++;
            @(negedge clk);
        end
        start_gen = 1'b0;
        if (cyc >= 400) begin
            failures++;
            $display("FAIL %s_timeout: sequence still at idx=%0d after %0d cycles, expected end", tag, idx, cyc);
        end
        checks++;
        if (done_gen !== 1'b1 || busy !== 1'b1 || addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: done=%b busy=%b valid=%b, expected done=1 busy=1 valid=0",
                     tag, done_gen, busy, addr_valid);
        end
        checks++;
        if (xfers != exp_xfers) begin
            failures++;
            $display("FAIL %s_count: transfers=%0d, expected %0d", tag, xfers, exp_xfers);
        end
        if (ready_pct == 100 && stall_idx < 0 && !swp) begin
            checks++;
            if (cyc != total) begin
                failures++;
                $display("FAIL %s_rate: cycles=%0d, expected %0d", tag, cyc, total);
            end
        end
        @(negedge clk);
        checks++;
        if (done_gen !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: done=%b busy=%b valid=%b, expected all 0", tag, done_gen, busy, addr_valid);
        end
        $display("txn %s len=%0d swap=%0b transfers=%0d cycles=%0d", tag, len, swp, xfers, cyc);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (addr_valid !== 1'b0 || addr !== '0 || addr_cnt !== '0 || done_gen !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b addr=%0d cnt=%0d done=%b busy=%b, expected all 0",
                     addr_valid, addr, addr_cnt, done_gen, busy);
        end
        rst_n = 1'b1;
        rst_b_n = 1'b1;
        @(negedge clk);
        $display("txn reset released");
    endtask

    task automatic test_zero_len;
        log2_len = '0;
        start_gen = 1'b1;
        @(negedge clk);
        start_gen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || addr_valid !== 1'b0) begin
                failures++;
                $display("FAIL zero_len: busy=%b valid=%b, expected 0 0", busy, addr_valid);
            end
            @(negedge clk);
        end
        $display("txn zero_len start ignored");
    endtask

    task automatic test_midrun_reset;
        log2_len = LB'(3);
        addr_ready = 1'b1;
        start_gen = 1'b1;
        @(negedge clk);
        start_gen = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (addr_cnt !== AB'(3) || addr_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pos: addr_cnt=%0d valid=%b, expected 3 1", addr_cnt, addr_valid);
        end
        rst_n = 1'b0;
        start_gen = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start_gen = 1'b0;
        checks++;
        if (addr_valid !== 1'b0 || addr !== '0 || addr_cnt !== '0 || done_gen !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: valid=%b addr=%0d cnt=%0d done=%b busy=%b, expected all 0",
                     addr_valid, addr, addr_cnt, done_gen, busy);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done_gen !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midrun_quiet: done=%b busy=%b, expected 0 0", done_gen, busy);
            end
            @(negedge clk);
        end
        $display("txn midrun reset abandoned sequence");
        run_seq(3, 1'b0, 100, -1, "after_reset");
    endtask

    task automatic test_clamp;
        int cyc;
        len_b = LB4'(6);
        ready_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (valid_b !== 1'b1 || cnt_b !== AB4'(i) || addr_b !== AB4'(rev_ref(i, 4))) begin
                failures++;
                $display("FAIL clamp_addr: valid=%b cnt=%0d addr=%0d, expected 1 %0d %0d",
                         valid_b, cnt_b, addr_b, i, rev_ref(i, 4));
            end
            @(negedge clk);
        end
        checks++;
        if (done_b !== 1'b1 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL clamp_done: done=%b valid=%b, expected 1 0", done_b, valid_b);
        end
        @(negedge clk);
        len_b = '0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        repeat (2) begin
            checks++;
            if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
                failures++;
                $display("FAIL clamp_zero_len: busy=%b valid=%b, expected 0 0", busy_b, valid_b);
            end
            cyc++;
            @(negedge clk);
        end
        $display("txn clamp len=6 -> 16 transfers, len=0 ignored");
    endtask

    initial begin
        test_reset();
        run_seq(3, 1'b0, 100, -1, "len3_full");
        run_seq(2, 1'b0, 100, -1, "len2_full");
        run_seq(1, 1'b0, 100, -1, "len1_b2b");
        run_seq(3, 1'b0, 100, 2, "backpressure");
        for (int k = 0; k < 6; k++)
            run_seq(1 + $urandom_range(2), 1'b0, 60, -1, "random_ready");
        test_zero_len();
        test_midrun_reset();
        test_clamp();
`ifdef BITREV_SWAP_EN
        run_seq(3, 1'b1, 100, -1, "swap_len3");
        run_seq(3, 1'b1, 50, -1, "swap_random");
        run_seq(2, 1'b1, 100, -1, "swap_len2");
        run_seq(3, 1'b0, 100, -1, "swap_off");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
